// File: rtl/cpu_muldiv.sv
// Iterative multiply/divide unit: shift-add MUL, restoring DIVU/DIVS/MODU/MODS.
// Define MULDIV_FAST_MUL_EN to replace the iterative MUL with a single-cycle multiply.
module cpu_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_DIVS = 3'b010;
  localparam logic [2:0] OP_MODU = 3'b011;
  localparam logic [2:0] OP_MODS = 3'b100;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic             w_signed_op;
  logic             w_sa;
  logic             w_sb;
  logic             w_spec;
  logic [WIDTH-1:0] w_spec_val;
  logic [WIDTH+1:0] w_sh;
  logic             w_ge;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_fix_val;

  assign w_signed_op = (op == OP_DIVS) || (op == OP_MODS);
  assign w_sa        = w_signed_op && data_a[WIDTH-1];
  assign w_sb        = w_signed_op && data_b[WIDTH-1];

  // Special cases bypass iteration entirely and complete the cycle after start.
  always_comb begin
    w_spec     = 1'b0;
    w_spec_val = '0;
    if (op > OP_MODS) begin
      w_spec = 1'b1;
    end else if (op != OP_MUL && data_b == '0) begin
      w_spec     = 1'b1;
      w_spec_val = (op == OP_DIVU || op == OP_DIVS) ? '1 : data_a;
    end else if (w_signed_op && data_a == MOST_NEG && data_b == '1) begin
      w_spec     = 1'b1;
      w_spec_val = (op == OP_DIVS) ? MOST_NEG : '0;
    end
  end

  // Restoring step: shift in the next dividend bit, subtract if the divisor fits.
  assign w_sh   = {r_rem, r_a[WIDTH-1]};
  assign w_ge   = w_sh >= {2'b00, r_b};
  assign w_diff = w_sh[WIDTH:0] - {1'b0, r_b};

  always_comb begin
    case (r_op)
      OP_DIVU: w_fix_val = r_a;
      OP_DIVS: w_fix_val = f_neg_if(r_a, r_sa ^ r_sb);
      OP_MODU: w_fix_val = r_rem[WIDTH-1:0];
      OP_MODS: w_fix_val = f_neg_if(r_rem[WIDTH-1:0], r_sa);
      default: w_fix_val = r_rem[WIDTH-1:0];
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0] w_prod;
  assign w_prod = data_a * data_b;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !kill) begin
            r_op <= op;
            r_sa <= w_sa;
            r_sb <= w_sb;
            if (w_spec) begin
              r_result <= w_spec_val;
              r_state  <= S_DONE;
            end else if (op == OP_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
              r_rem   <= {1'b0, w_prod};
              r_state <= S_FIX;
`else
              r_a     <= data_a;
              r_b     <= data_b;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_state <= S_MUL;
`endif
            end else begin
              r_a     <= f_neg_if(data_a, w_sa);
              r_b     <= f_neg_if(data_b, w_sb);
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            if (r_b[0]) r_rem <= {1'b0, r_rem[WIDTH-1:0] + r_a};
            r_a <= {r_a[WIDTH-2:0], 1'b0};
            r_b <= {1'b0, r_b[WIDTH-1:1]};
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_ge ? w_diff : w_sh[WIDTH:0];
            r_a   <= {r_a[WIDTH-2:0], w_ge};
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_val;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
